// File: rtl/avg_pkg.sv
// Shared definitions for average_filter and the stages around it.
package avg_pkg;
   localparam int DEF_DATA_WIDTH = 8;
   typedef logic [DEF_DATA_WIDTH-1:0] sample_t;
endpackage

// File: rtl/sample_pacer_if.sv
// Valid/ready sample handshake between a bursty source and sample_pacer.
interface sample_pacer_if
   import avg_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH
) ();
   logic                  s_valid;
   logic                  s_ready;
   logic [DATA_WIDTH-1:0] s_data;

   modport master (output s_valid, output s_data, input s_ready);
   modport slave  (input s_valid, input s_data, output s_ready);
endinterface

// File: rtl/sample_fifo.sv
// Synchronous FIFO with registered full/empty flags and an occupancy count.
module sample_fifo
   import avg_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                            clk,
   input  logic                            reset_n,
   input  logic                            push,
   input  logic [DATA_WIDTH-1:0]           wdata,
   input  logic                            pop,
   output logic [DATA_WIDTH-1:0]           rdata,
   output logic                            full,
   output logic                            empty,
   output logic [$clog2(FIFO_DEPTH+1)-1:0] count
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = $clog2(FIFO_DEPTH+1);

   logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
   logic [AW-1:0]         wr_ptr;
   logic [AW-1:0]         rd_ptr;
   logic                  do_push;
   logic                  do_pop;
   logic [CW-1:0]         count_nxt;

   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rdata   = mem[rd_ptr];

   always_comb begin
      count_nxt = count;
      case ({do_push, do_pop})
         2'b10:   count_nxt = count + CW'(1);
         2'b01:   count_nxt = count - CW'(1);
         default: count_nxt = count;
      endcase
   end

   // Flags are derived from the next count so they are plain registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         full   <= 1'b0;
         empty  <= 1'b1;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         count <= count_nxt;
         full  <= (count_nxt == CW'(FIFO_DEPTH));
         empty <= (count_nxt == '0);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end
endmodule

// File: rtl/sample_pacer.sv
// Buffers bursty samples and releases them as evenly spaced one-cycle strobes.
module sample_pacer
   import avg_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int FIFO_DEPTH = 4,
   parameter int DIV_WIDTH  = 8
) (
   input  logic                            clk,
   input  logic                            reset_n,
   sample_pacer_if.slave                   src,
   input  logic                            i_enable,
   input  logic [DIV_WIDTH-1:0]            i_div,
   input  logic                            i_clear,
   output logic                            o_ce,
   output logic [DATA_WIDTH-1:0]           o_data,
   output logic [$clog2(FIFO_DEPTH+1)-1:0] o_fill,
   output logic                            o_underrun
);
   logic [DIV_WIDTH-1:0]  cnt;
   logic                  tick;
   logic                  pop;
   logic                  full;
   logic                  empty;
   logic [DATA_WIDTH-1:0] head;

   assign tick        = i_enable && (cnt == '0);
   assign pop         = tick && !empty;
   assign src.s_ready = !full;

   sample_fifo #(
      .DATA_WIDTH (DATA_WIDTH),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .push    (src.s_valid && !full),
      .wdata   (src.s_data),
      .pop     (pop),
      .rdata   (head),
      .full    (full),
      .empty   (empty),
      .count   (o_fill)
   );

   // A new divider value is only picked up on reload.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)           cnt <= '0;
      else if (!i_enable)     cnt <= '0;
      else if (cnt == '0)     cnt <= i_div;
      else                    cnt <= cnt - DIV_WIDTH'(1);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         o_ce       <= 1'b0;
         o_data     <= '0;
         o_underrun <= 1'b0;
      end else begin
         o_ce <= pop;
         if (pop) o_data <= head;
         if (tick && empty) o_underrun <= 1'b1;
         else if (i_clear)  o_underrun <= 1'b0;
      end
   end
endmodule
